// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   Start  launch MDOp 1..4 (mult, multu, div, divu) when idle
//   MDOp   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others none
//   SrcA   dividend / multiplicand / mthi-mtlo data
//   SrcB   divisor / multiplier
//   RdHi   MDRes select (1 = HI, 0 = LO)
//   Busy   operation in flight
//   HI, LO committed architectural registers
//   MDRes  RdHi ? HI : LO
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        RdHi,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDRes
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    logic [CW-1:0] cnt;
    logic [31:0] res_hi, res_lo;
    logic        res_ok;
    logic        is_mul, is_div, sgn, launch, b_zero;
    logic [63:0] sprod, uprod, result;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
    // The result is computed at launch and held until the latency expires.
    // Signed division works on magnitudes so that 0x8000_0000 / -1 yields
    // 0x8000_0000 without relying on the undefined signed-overflow case.
    always_comb begin
        is_mul = MDOp == 4'd1 || MDOp == 4'd2;
        is_div = MDOp == 4'd3 || MDOp == 4'd4;
        sgn    = MDOp == 4'd1 || MDOp == 4'd3;
        launch = Start && !Busy && (is_mul || is_div);
        b_zero = SrcB == 32'd0;
        a_mag  = (sgn && SrcA[31]) ? -SrcA : SrcA;
        b_mag  = (sgn && SrcB[31]) ? -SrcB : SrcB;
        q_mag  = a_mag / (b_zero ? 32'd1 : b_mag);
        r_mag  = a_mag % (b_zero ? 32'd1 : b_mag);
        quo    = (sgn && (SrcA[31] ^ SrcB[31])) ? -q_mag : q_mag;
        rem    = (sgn && SrcA[31]) ? -r_mag : r_mag;
        sprod  = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
        uprod  = {32'd0, SrcA} * {32'd0, SrcB};
        result = is_div ? {rem, quo} : (sgn ? sprod : uprod);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Busy   <= 1'b0;
            cnt    <= '0;
            HI     <= '0;
            LO     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_ok <= 1'b0;
        end else if (Busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                Busy <= 1'b0;
                // A zero divisor still takes the full latency but commits nothing.
                if (res_ok) begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end
        end else begin
            if (launch) begin
                Busy             <= 1'b1;
                cnt              <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                {res_hi, res_lo} <= result;
                res_ok           <= !(is_div && b_zero);
            end
            if (MDOp == 4'd5) HI <= SrcA;
            if (MDOp == 4'd6) LO <= SrcA;
        end
    end
    assign MDRes = RdHi ? HI : LO;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  MDOp = 4'd0;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        RdHi = 1'b0;
    logic        Busy;
    logic [31:0] HI, LO, MDRes;
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .SrcA(SrcA),
        .SrcB(SrcB), .RdHi(RdHi), .Busy(Busy), .HI(HI), .LO(LO), .MDRes(MDRes)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint q, r;
        if (op == 1) return 64'(sa * sb);
        if (op == 2) return 64'(ua * ub);
        if (b == 32'd0) return {m_hi, m_lo};
        q = (op == 3) ? sa / sb : ua / ub;
        r = (op == 3) ? sa % sb : ua % ub;
        return {r[31:0], q[31:0]};
    endfunction

    // Called at a negedge; returns at the negedge after the launch edge.
    task automatic launch(input int op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        Start = 1'b1;
        MDOp = 4'(op);
        SrcA = a;
        SrcB = b;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        MDOp = 4'd0;
    endtask

    task automatic wait_done(input string name, input int n);
        int c = 0;
        logic [63:0] e;
        while (Busy === 1'b1 && c < 40) begin
            c++;
            @(negedge clk);
        end
        checks++;
        if (c !== n) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, c, n);
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got 0 want 1", name);
        end else begin
            e = exp_q.pop_front();
            m_hi = e[63:32];
            m_lo = e[31:0];
            checks++;
            if (HI !== m_hi) begin
                errors++;
                $display("FAIL %s HI got %h want %h", name, HI, m_hi);
            end
            checks++;
            if (LO !== m_lo) begin
                errors++;
                $display("FAIL %s LO got %h want %h", name, LO, m_lo);
            end
        end
    endtask

    task automatic move(input int op, input logic [31:0] a);
        Start = 1'b1;
        MDOp = 4'(op);
        SrcA = a;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        MDOp = 4'd0;
        if (op == 5) m_hi = a;
        else m_lo = a;
        checks++;
        if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            errors++;
            $display("FAIL move%0d busy/hi/lo got %b %h %h want 0 %h %h", op, Busy, HI, LO, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got %b %h %h want 0 0 0", Busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        move(5, 32'hAAAA_5555);
        launch(1, 32'hFFFF_FFFE, 32'h3, 64'hFFFF_FFFF_FFFF_FFFA);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDRes !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got %b %h %h %h want 0 0 0 0", Busy, HI, LO, MDRes);
        end
        exp_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL no_late_commit got %b %h %h want 0 0 0", Busy, HI, LO);
        end
    endtask

    task automatic test_mult();
        launch(1, 32'hFFFF_FFFE, 32'h3, 64'hFFFF_FFFF_FFFF_FFFA);
        wait_done("mult", 5);
        launch(2, 32'hFFFF_FFFE, 32'h3, 64'h0000_0002_FFFF_FFFA);
        wait_done("multu", 5);
    endtask

    task automatic test_div();
        launch(3, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done("div_neg", 10);
        launch(4, 32'hFFFF_FFF9, 32'h2, 64'h0000_0001_7FFF_FFFC);
        wait_done("divu", 10);
        launch(3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        wait_done("div_ovf", 10);
    endtask

    task automatic test_divzero();
        move(5, 32'h1234_5678);
        move(6, 32'h9ABC_DEF0);
        launch(3, 32'd5, 32'd0, 64'h1234_5678_9ABC_DEF0);
        wait_done("div_zero", 10);
        launch(4, 32'd5, 32'd0, 64'h1234_5678_9ABC_DEF0);
        wait_done("divu_zero", 10);
    endtask

    task automatic test_back_to_back();
        launch(3, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        Start = 1'b1;
        MDOp = 4'd1;
        SrcA = 32'd3;
        SrcB = 32'd3;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        MDOp = 4'd5;
        SrcA = 32'hDEAD_BEEF;
        RdHi = 1'b0;
        checks++;
        if (MDRes !== m_lo) begin
            errors++;
            $display("FAIL inflight_mdres got %h want %h", MDRes, m_lo);
        end
        @(posedge clk);
        @(negedge clk);
        MDOp = 4'd0;
        wait_done("masked_div", 8);
        launch(1, 32'd3, 32'd3, 64'd9);
        wait_done("b2b_mult", 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int op = int'($urandom_range(1, 4));
            logic [31:0] a = $urandom();
            logic [31:0] b = (i == 3) ? 32'd0 : $urandom();
            launch(op, a, b, model(op, a, b));
            wait_done("random", (op <= 2) ? 5 : 10);
        end
    endtask

    task automatic test_readout();
        move(6, 32'h55AA_55AA);
        for (int i = 0; i < 6; i++) begin
            RdHi = i[0];
            #1;
            checks++;
            if (MDRes !== (i[0] ? m_hi : 32'h55AA_55AA)) begin
                errors++;
                $display("FAIL readout got %h want %h", MDRes, i[0] ? m_hi : 32'h55AA_55AA);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_back_to_back();
        test_random();
        test_readout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the execute stage, sitting beside the ALU and consuming the same SrcA/SrcB operands from the register file. It executes mult/multu/div/divu over a fixed multi-cycle latency and owns the HI/LO architectural registers. It accepts mthi/mtlo writes and provides mfhi/mflo read data to the write-back mux. The hazard unit stalls the pipeline while `Busy` or `Start` is high.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Start  input  1  launch the operation on MDOp (ops 1–4 only)
- MDOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; others = none
- SrcA  input  32  rs operand (dividend / multiplicand / mthi/mtlo data)
- SrcB  input  32  rt operand (divisor / multiplier)
- RdHi  input  1  MDRes select: 1 = HI, 0 = LO
- Busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- MDRes  output  32  combinational RdHi ? HI : LO

## Operation
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, counter=0; pending results discarded.
- Idle (Busy=0), Start=1, MDOp in 1..4: latch the computed result into internal result registers at this edge. Load counter with MULT_CYCLES or DIV_CYCLES. Go Busy.
- Idle, MDOp=5 (Start ignored): HI<=SrcA at the edge. MDOp=6: LO<=SrcA. Busy is unaffected.
- Busy: counter decrements each edge. At the edge where it reaches 0, HI/LO are loaded from the result registers and Busy clears.
- Start, mthi and mtlo are all ignored while Busy=1; the hazard unit guarantees none are issued then.
- Start=1 with MDOp of 0, 5, 6 or 7–15 does not launch an operation. MDOp 5/6 still perform their move.
- mult: signed 32x32 to 64. HI=product[63:32], LO=product[31:0]. multu: same, unsigned.
- div: signed. LO=quotient truncated toward zero. HI=remainder with the sign of the dividend. 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0.
- divu: unsigned quotient/remainder.
- Divisor 0 (div/divu): full DIV_CYCLES latency. HI/LO are left unchanged at completion.
- MDRes is purely combinational from HI/LO/RdHi. It shows committed values only and never the in-flight result.

## Timing
- Launch at edge k. Busy=1 from k until edge k+N; HI/LO are updated at edge k+N, together with Busy falling. N=5 for mult/multu, N=10 for div/divu.
- Back-to-back: a new Start is accepted at the first edge where Busy=0, i.e. edge k+N+1 at the earliest.
- mthi/mtlo: single edge, no Busy. MDRes reflects the new value in the cycle after that edge.
- Reset asserted mid-operation: Busy drops immediately (asynchronously) and HI/LO read 0. After release, no late commit of the old result occurs.
- Reset released: first Start is accepted at the first rising edge with reset=1.

## Test plan
- Reset: hold reset=0 mid-mult -> Busy=0, HI=LO=0 immediately. Release and wait 10 cycles -> HI/LO remain 0.
- mult 0xFFFF_FFFE x 0x0000_0003 -> Busy high exactly 5 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. Repeat as multu -> HI=0x0000_0002, LO=0xFFFF_FFFA.
- div -7 / 2 -> after 10 cycles LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. divu 0xFFFF_FFF9 / 2 -> LO=0x7FFF_FFFC, HI=1. div 0x8000_0000 / -1 -> LO=0x8000_0000, HI=0.
- Divide by zero: preload HI=0x1234_5678 via mthi and LO=0x9ABC_DEF0 via mtlo, then div 5/0 -> Busy 10 cycles, HI/LO unchanged.
- Busy-time masking: Start div 100/7. During Busy, issue Start mult 3x3 and MDOp=5 with SrcA=0xDEAD_BEEF -> all ignored. Final HI=2, LO=14. Then mult 3x3 issued on the first idle edge -> LO=9 after 5 cycles.
- Readout: mtlo 0x55AA_55AA, then RdHi toggling 0/1 -> MDRes alternates between 0x55AA_55AA and the current HI value on the same cycle.
